// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR widths, CSR address map, op encodings and access-unit state enum
package csr_pkg;
  localparam int CSR_ADDR_W = 14;
  localparam int CSR_DATA_W = 32;
  localparam int CSR_RD_W   = 5;
  localparam logic [13:0] CSR_CRMD   = 14'h0;
  localparam logic [13:0] CSR_PRMD   = 14'h1;
  localparam logic [13:0] CSR_EUEN   = 14'h2;
  localparam logic [13:0] CSR_ECFG   = 14'h4;
  localparam logic [13:0] CSR_ESTAT  = 14'h5;
  localparam logic [13:0] CSR_ERA    = 14'h6;
  localparam logic [13:0] CSR_BADV   = 14'h7;
  localparam logic [13:0] CSR_EENTRY = 14'hc;
  localparam logic [13:0] CSR_SAVE0  = 14'h30;
  localparam logic [13:0] CSR_TID    = 14'h40;
  localparam logic [13:0] CSR_TCFG   = 14'h41;
  localparam logic [13:0] CSR_DMW0   = 14'h180;
  localparam logic [13:0] CSR_DMW1   = 14'h181;
  typedef enum logic [1:0] {CSR_OP_RD, CSR_OP_WR, CSR_OP_XCHG, CSR_OP_ILL} csr_op_e;
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;
endpackage

// File: rtl/csr_access_unit_if.sv
// csr_access_unit_if: request, response and CSR-file port bundle
//   slave modport: the access unit; master modport: EX/writeback/CSR-file side
interface csr_access_unit_if #(
  parameter int CSR_AW = csr_pkg::CSR_ADDR_W,
  parameter int DW     = csr_pkg::CSR_DATA_W,
  parameter int RD_W   = csr_pkg::CSR_RD_W
);
  logic              req_valid, req_ready;
  logic [1:0]        req_op;
  logic [CSR_AW-1:0] req_addr;
  logic [DW-1:0]     req_wdata, req_mask;
  logic [RD_W-1:0]   req_rd;
  logic              resp_valid, resp_ready, resp_err;
  logic [DW-1:0]     resp_rdata;
  logic [RD_W-1:0]   resp_rd;
  logic [CSR_AW-1:0] csr_raddr, csr_waddr;
  logic [DW-1:0]     csr_rdata, csr_wdata;
  logic              csr_wr_en;
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_mask, req_rd, resp_ready, csr_rdata,
    output req_ready, resp_valid, resp_rdata, resp_rd, resp_err, csr_raddr, csr_wr_en, csr_waddr, csr_wdata
  );
  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_mask, req_rd, resp_ready, csr_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_rd, resp_err, csr_raddr, csr_wr_en, csr_waddr, csr_wdata
  );
endinterface

// File: rtl/csr_xchg_merge.sv
// csr_xchg_merge: new CSR value; xchg merges wdata into old under mask, otherwise wdata
//   old_i, wdata_i, mask_i, is_xchg_i -> wdata_o
module csr_xchg_merge #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] old_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [DW-1:0] mask_i,
  input  logic          is_xchg_i,
  output logic [DW-1:0] wdata_o
);
  assign wdata_o = is_xchg_i ? (old_i & ~mask_i) | (wdata_i & mask_i) : wdata_i;
endmodule

// File: rtl/csr_access_unit.sv
// csr_access_unit: sequences csrrd/csrwr/csrxchg as read -> optional write -> response
//   clk, reset (sync, active-high), flush (aborts transaction), cur_plv (privilege at accept)
//   bus: slave side of csr_access_unit_if (request, response, CSR-file port)
//   CSR_PLV_CHECK_EN: when defined, a request accepted at cur_plv!=0 is rejected with resp_err
module csr_access_unit import csr_pkg::*; #(
  parameter int CSR_AW = CSR_ADDR_W,
  parameter int DW     = CSR_DATA_W,
  parameter int RD_W   = CSR_RD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [1:0]       cur_plv,
  csr_access_unit_if.slave bus
);
  state_e            state_q, state_d;
  csr_op_e           op_q;
  logic [CSR_AW-1:0] addr_q;
  logic [DW-1:0]     wdata_q, mask_q, old_q, old_d, old_rd, merged;
  logic [RD_W-1:0]   rd_q;
  logic              err_q, err_d, accept, deny;
  assign accept = state_q == IDLE && bus.req_valid && !flush;
`ifdef CSR_PLV_CHECK_EN
  logic plv_q;
  always_ff @(posedge clk) plv_q <= reset ? 1'b0 : accept ? (cur_plv != 2'd0) : plv_q;
  assign deny   = op_q == CSR_OP_ILL || plv_q;
  assign old_rd = plv_q ? '0 : bus.csr_rdata;
`else
  logic unused_plv;
  assign unused_plv = ^cur_plv;
  assign deny       = op_q == CSR_OP_ILL;
  assign old_rd     = bus.csr_rdata;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= CSR_OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      rd_q    <= '0;
      old_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      old_q   <= old_d;
      err_q   <= err_d;
      if (accept) begin
        op_q    <= csr_op_e'(bus.req_op);
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        mask_q  <= bus.req_mask;
        rd_q    <= bus.req_rd;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    old_d   = old_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE:  state_d = accept ? READ : IDLE;
      READ: begin
        state_d = flush ? IDLE : (deny || op_q == CSR_OP_RD) ? RESP : WRITE;
        old_d   = old_rd;
        err_d   = deny;
      end
      WRITE: state_d = flush ? IDLE : RESP;
      RESP:  state_d = (flush || bus.resp_ready) ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  csr_xchg_merge #(.DW(DW)) u_merge (
    .old_i     (old_q),
    .wdata_i   (wdata_q),
    .mask_i    (mask_q),
    .is_xchg_i (op_q == CSR_OP_XCHG),
    .wdata_o   (merged)
  );
  // a flushed response is withdrawn in the same cycle so writeback never sees it
  assign bus.req_ready  = state_q == IDLE;
  assign bus.resp_valid = state_q == RESP && !flush;
  assign bus.resp_rdata = state_q == RESP ? old_q : '0;
  assign bus.resp_rd    = state_q == RESP ? rd_q : '0;
  assign bus.resp_err   = state_q == RESP && err_q;
  assign bus.csr_raddr  = state_q == READ ? addr_q : '0;
  assign bus.csr_wr_en  = state_q == WRITE;
  assign bus.csr_waddr  = state_q == WRITE ? addr_q : '0;
  assign bus.csr_wdata  = state_q == WRITE ? merged : '0;
endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit: randomized scoreboard bench for csr_access_unit with a CSR-file model
module tb_csr_access_unit;
  typedef struct packed {logic [4:0] rd; logic [31:0] rdata; logic err;} resp_t;
  typedef struct packed {logic [13:0] addr; logic [31:0] data;} wr_t;
  logic clk = 0, reset = 1, flush = 0, force_bp = 0;
  logic [1:0] cur_plv = 0;
  logic [31:0] mem [0:16383];
  logic [31:0] ref_mem [0:16383];
  logic [13:0] alist [8] = '{14'h0, 14'h1, 14'h5, 14'h6, 14'h30, 14'h40, 14'h180, 14'h181};
  resp_t rq[$];
  wr_t   wq[$];
  int n_tests = 0, n_fail = 0;
  csr_access_unit_if bus();
  csr_access_unit dut (.clk(clk), .reset(reset), .flush(flush), .cur_plv(cur_plv), .bus(bus));
  always #5 clk = ~clk;
  assign bus.csr_rdata = mem[bus.csr_raddr];
  always @(posedge clk) if (bus.csr_wr_en) mem[bus.csr_waddr] <= bus.csr_wdata;
  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (bus.resp_valid && bus.resp_ready) begin
        if (rq.size() == 0) check("spurious_resp", 1, 0);
        else begin
          e = rq.pop_front();
          check("resp_rdata", bus.resp_rdata, e.rdata);
          check("resp_rd", {27'd0, bus.resp_rd}, {27'd0, e.rd});
          check("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
        end
      end
    end
  end
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (bus.csr_wr_en) begin
        if (wq.size() == 0) check("spurious_write", 1, 0);
        else begin
          w = wq.pop_front();
          check("csr_waddr", {18'd0, bus.csr_waddr}, {18'd0, w.addr});
          check("csr_wdata", bus.csr_wdata, w.data);
        end
      end
    end
  end
  initial begin
    bus.resp_ready = 0;
    forever begin
      @(posedge clk); #2;
      bus.resp_ready = force_bp ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  task automatic preset(input logic [13:0] a, input logic [31:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask
  task automatic wait_ready();
    int k = 0;
    while (!bus.req_ready && k < 50) begin @(posedge clk); #1; k++; end
    if (!bus.req_ready) check("req_ready_timeout", 0, 1);
  endtask
  // fl: 0 none, 1 flush in READ, 2 flush in WRITE, 3 flush in RESP
  task automatic txn(input logic [1:0] op, input logic [13:0] a, input logic [31:0] wd, input logic [31:0] mk,
                     input logic [4:0] rd, input logic [1:0] plv, input int fl_in);
    logic deny, wr;
    logic [31:0] old, nv;
    int lat, fl;
    fl = fl_in;
    wait_ready();
    bus.req_valid = 1; bus.req_op = op; bus.req_addr = a; bus.req_wdata = wd; bus.req_mask = mk;
    bus.req_rd = rd; cur_plv = plv;
    @(posedge clk); #1;
    bus.req_valid = 0; bus.req_op = 2'($urandom); bus.req_addr = 14'($urandom);
    bus.req_wdata = $urandom; bus.req_mask = $urandom; bus.req_rd = 5'($urandom); cur_plv = 2'($urandom);
    deny = op == 2'b11;
`ifdef CSR_PLV_CHECK_EN
    deny = deny || plv != 0;
`endif
    wr  = !deny && op != 2'b00;
    old = ref_mem[a];
    nv  = op == 2'b10 ? (old & ~mk) | (wd & mk) : wd;
    lat = wr ? 3 : 2;
    if (fl == 2 && !wr) fl = 0;
    if (fl == 1) begin
      flush = 1; @(posedge clk); #1; flush = 0;
      check("flush_read_ready", {31'd0, bus.req_ready}, 1);
      return;
    end
    if (wr) begin
      wq.push_back('{addr: a, data: nv});
      ref_mem[a] = nv;
    end
    if (fl == 2) begin
      @(posedge clk); #1; flush = 1; @(posedge clk); #1; flush = 0;
      check("flush_write_ready", {31'd0, bus.req_ready}, 1);
      return;
    end
    if (fl == 0) rq.push_back('{rd: rd, rdata: (deny && op != 2'b11) ? 32'd0 : old, err: deny});
    repeat (lat - 2) begin @(posedge clk); #1; end
    check("resp_valid_early", {31'd0, bus.resp_valid}, 0);
    @(posedge clk); #1;
    if (fl == 3) begin
      flush = 1; #3;
      check("flush_resp_valid", {31'd0, bus.resp_valid}, 0);
      @(posedge clk); #1; flush = 0;
      check("flush_resp_ready", {31'd0, bus.req_ready}, 1);
      return;
    end
    check("resp_valid_lat", {31'd0, bus.resp_valid}, 1);
  endtask
  initial begin
    int k;
    bus.req_valid = 0; bus.req_op = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.req_mask = 0; bus.req_rd = 0;
    for (int i = 0; i < 16384; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    repeat (3) @(posedge clk);
    #1; reset = 0;
    check("rst_req_ready", {31'd0, bus.req_ready}, 1);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 0);
    check("rst_resp_err", {31'd0, bus.resp_err}, 0);
    check("rst_wr_en", {31'd0, bus.csr_wr_en}, 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_addrs", {4'd0, bus.csr_raddr, bus.csr_waddr}, 0);
    check("rst_wdata", bus.csr_wdata, 0);
    preset(14'h5, 32'h0000_1234);
    txn(2'b00, 14'h5, 32'h0, 32'h0, 5'd1, 2'd0, 0);
    preset(14'h30, 32'hAAAA_AAAA);
    txn(2'b01, 14'h30, 32'h5555_5555, 32'h0, 5'd2, 2'd0, 0);
    preset(14'h40, 32'hFF00_FF00);
    txn(2'b10, 14'h40, 32'h1234_5678, 32'h0000_FFFF, 5'd3, 2'd0, 0);
    wait_ready();
    preset(14'h6, 32'hCAFE_0001);
    force_bp = 1;
    txn(2'b00, 14'h6, 32'h0, 32'h0, 5'd7, 2'd0, 0);
    repeat (5) begin
      check("bp_valid", {31'd0, bus.resp_valid}, 1);
      check("bp_rdata", bus.resp_rdata, 32'hCAFE_0001);
      check("bp_rd", {27'd0, bus.resp_rd}, 7);
      check("bp_req_ready", {31'd0, bus.req_ready}, 0);
      @(posedge clk); #1;
    end
    force_bp = 0;
    txn(2'b01, 14'h30, 32'h1111_2222, 32'h0, 5'd4, 2'd0, 1);
    txn(2'b11, 14'h180, 32'h9999_9999, 32'hFFFF_FFFF, 5'd5, 2'd0, 0);
    txn(2'b01, 14'h181, 32'h7777_0000, 32'h0, 5'd6, 2'd3, 0);
    wait_ready();
    preset(14'h181, 32'h0);
    bus.req_valid = 1; bus.req_op = 2'b01; bus.req_addr = 14'h181; bus.req_wdata = 32'hDEAD_BEEF; bus.req_rd = 5'd9;
    cur_plv = 0;
    @(posedge clk); #1;
    bus.req_valid = 0;
    wq.push_back('{addr: 14'h181, data: 32'hDEAD_BEEF});
    ref_mem[14'h181] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check("rst_write_strobe", {31'd0, bus.csr_wr_en}, 1);
    reset = 1;
    @(posedge clk); #1;
    check("rst_in_write_wr_en", {31'd0, bus.csr_wr_en}, 0);
    check("rst_in_write_ready", {31'd0, bus.req_ready}, 1);
    reset = 0;
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 9);
      txn(k < 3 ? 2'b00 : k < 6 ? 2'b01 : k < 9 ? 2'b10 : 2'b11, alist[$urandom_range(0, 7)], $urandom, $urandom,
          5'($urandom), $urandom_range(0, 7) == 0 ? 2'($urandom) : 2'd0,
          $urandom_range(0, 9) == 0 ? int'($urandom_range(1, 3)) : 0);
    end
    k = 0;
    while ((rq.size() != 0 || wq.size() != 0) && k < 100) begin @(posedge clk); #1; k++; end
    check("drain_resp", rq.size(), 0);
    check("drain_write", wq.size(), 0);
    for (int i = 0; i < 8; i++) check("final_mem", mem[alist[i]], ref_mem[alist[i]]);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
